// File: rtl/adder_arbiter_if.sv
// Handshake bundle between the requesters/result consumer and the
// shared-adder arbiter. The arbiter side uses the slave modport.
interface adder_arbiter_if #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a_bus;
    logic [NUM_REQ*WIDTH-1:0] b_bus;
    logic [NUM_REQ-1:0]       cin_bus;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic                     res_valid;
    logic                     res_ready;
    logic [ID_W-1:0]          res_id;
    logic [WIDTH-1:0]         res_sum;
    logic                     res_cout;
    logic                     res_parity;

    modport master (
        output req, a_bus, b_bus, cin_bus, res_ready,
        input  gnt, busy, res_valid, res_id, res_sum, res_cout, res_parity
    );

    modport slave (
        input  req, a_bus, b_bus, cin_bus, res_ready,
        output gnt, busy, res_valid, res_id, res_sum, res_cout, res_parity
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Macro ADDER_ARB_CIN_EN: defined -> cin_bus feeds carry-in; undefined -> carry-in 0.
module adder_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ADDER_ARB_CIN_EN
    localparam logic CIN_EN = 1'b1;
`else
    localparam logic CIN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ADD    = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   next_win;
    logic               found;
    logic [IDX_W-1:0]   cand;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_cin;
    logic [WIDTH:0]     total;
    logic [NUM_REQ-1:0] gnt_r;
    logic               busy_r;
    logic               valid_r;
    logic [ID_W-1:0]    id_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               par_r;

    // Round-robin search: first requester after last_ptr, wrapping to 0.
    always_comb begin
        next_win = last_ptr;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_ptr) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found    = 1'b1;
                next_win = cand;
            end
        end
    end

    assign total = {1'b0, op_a} + {1'b0, op_b} + (WIDTH + 1)'(op_cin);

    // Sequencer: arbitrate, grant, add, then hold the result until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_ptr <= IDX_W'(NUM_REQ - 1);
            winner   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            gnt_r    <= '0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            id_r     <= '0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
            par_r    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        winner   <= next_win;
                        last_ptr <= next_win;
                        gnt_r    <= NUM_REQ'(1) << next_win;
                        busy_r   <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    op_a   <= bus.a_bus[int'(winner) * WIDTH +: WIDTH];
                    op_b   <= bus.b_bus[int'(winner) * WIDTH +: WIDTH];
                    op_cin <= CIN_EN & bus.cin_bus[winner];
                    gnt_r  <= '0;
                    state  <= ADD;
                end
                ADD: begin
                    sum_r   <= total[WIDTH-1:0];
                    cout_r  <= total[WIDTH];
                    par_r   <= ~total[0];
                    id_r    <= ID_W'(winner);
                    valid_r <= 1'b1;
                    state   <= RESULT;
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt        = gnt_r;
    assign bus.busy       = busy_r;
    assign bus.res_valid  = valid_r;
    assign bus.res_id     = id_r;
    assign bus.res_sum    = sum_r;
    assign bus.res_cout   = cout_r;
    assign bus.res_parity = par_r;
endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: transaction model plus
// directed vectors with hand-computed results.
module tb_adder_arbiter;
    localparam int W  = 4;
    localparam int NR = 4;
    localparam int IW = 2;

`ifdef ADDER_ARB_CIN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    adder_arbiter_if #(.WIDTH(W), .NUM_REQ(NR), .ID_W(IW)) bus ();

    adder_arbiter #(.WIDTH(W), .NUM_REQ(NR), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter for grant spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int rr(input int last, input logic [NR-1:0] r);
        int c;
        for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            if (r[c]) return c;
        end
        return last;
    endfunction

    // Transaction model: a job is born from req while free, its grant
    // shows in its first cycle, the result two cycles later.
    bit started = 0;
    bit m_job;
    int m_age;
    int m_win;
    int m_ptr;
    int m_a, m_b, m_c;
    bit m_valid;
    int m_id, m_sum, m_cout, m_par;

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            m_job   = 0;
            m_age   = 0;
            m_ptr   = NR - 1;
            m_valid = 0;
            m_id    = 0;
            m_sum   = 0;
            m_cout  = 0;
            m_par   = 1;
        end else if (started) begin
            if (!m_job) begin
                if (bus.req != 0) begin
                    m_win = rr(m_ptr, bus.req);
                    m_ptr = m_win;
                    m_job = 1;
                    m_age = 0;
                end
            end else begin
                m_age++;
                if (m_age == 1) begin
                    m_a = int'(bus.a_bus[m_win*W +: W]);
                    m_b = int'(bus.b_bus[m_win*W +: W]);
                    m_c = CIN_EN ? int'(bus.cin_bus[m_win]) : 0;
                end else if (m_age == 2) begin
                    m_sum   = (m_a + m_b + m_c) % (1 << W);
                    m_cout  = (m_a + m_b + m_c) / (1 << W);
                    m_par   = (m_sum % 2 == 0) ? 1 : 0;
                    m_id    = m_win;
                    m_valid = 1;
                end else if (bus.res_ready) begin
                    m_valid = 0;
                    m_job   = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("m_gnt", bus.gnt, (m_job && m_age == 0) ? (1 << m_win) : 0);
            check("m_busy", bus.busy, m_job);
            check("m_valid", bus.res_valid, m_valid);
            check("m_id", bus.res_id, m_id);
            check("m_sum", bus.res_sum, m_sum);
            check("m_cout", bus.res_cout, m_cout);
            check("m_par", bus.res_parity, m_par);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", bus.busy, 0);
    endtask

    task automatic single(input int id, input int a, input int b, input int c,
                          input int es, input int ec, input int ep);
        wait_idle();
        bus.req     = '0;
        bus.req[id] = 1'b1;
        bus.a_bus   = '0;
        bus.b_bus   = '0;
        bus.cin_bus = '0;
        bus.a_bus[id*W +: W] = W'(a);
        bus.b_bus[id*W +: W] = W'(b);
        bus.cin_bus[id] = c[0];
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("sgl_gnt", bus.gnt, 1 << id);
        bus.req = '0;
        @(negedge clk);
        bus.a_bus   = 16'($urandom);
        bus.b_bus   = 16'($urandom);
        bus.cin_bus = 4'($urandom);
        @(negedge clk);
        check("sgl_valid", bus.res_valid, 1);
        check("sgl_id", bus.res_id, id);
        check("sgl_sum", bus.res_sum, es);
        check("sgl_cout", bus.res_cout, ec);
        check("sgl_par", bus.res_parity, ep);
        @(negedge clk);
        check("sgl_done", bus.res_valid, 0);
    endtask

    initial begin
        int n;
        int last_c;
        rst           = 1'b1;
        bus.req       = 4'b1111;
        bus.a_bus     = '0;
        bus.b_bus     = '0;
        bus.cin_bus   = '0;
        bus.res_ready = 1'b0;

        // reset with all requests high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_gnt", bus.gnt, 0);
            check("rst_valid", bus.res_valid, 0);
            check("rst_par", bus.res_parity, 1);
            check("rst_busy", bus.busy, 0);
        end
        rst     = 1'b0;
        bus.req = '0;
        @(negedge clk);

        // single request, overflow, all-ones corner
        single(2, 3, 4, 1, CIN_EN ? 8 : 7, 0, CIN_EN ? 1 : 0);
        single(0, 15, 1, 0, 0, 1, 1);
        single(3, 15, 15, 1, CIN_EN ? 15 : 14, 1, CIN_EN ? 0 : 1);

        // round-robin with all requesters held
        wait_idle();
        bus.req       = 4'b1111;
        bus.a_bus     = 16'h1234;
        bus.b_bus     = 16'h5678;
        bus.cin_bus   = 4'b1010;
        bus.res_ready = 1'b1;
        last_c        = 0;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (bus.gnt == 0 && n < 8) begin
                @(negedge clk);
                n++;
            end
            check("rr_gnt", bus.gnt, 1 << (g % 4));
            if (g > 0) check("rr_gap", cyc - last_c, 4);
            last_c = cyc;
            if (g == 4) bus.req = '0;
            @(negedge clk);
        end

        // backpressure while req toggles
        wait_idle();
        bus.req       = 4'b0010;
        bus.a_bus     = 16'h0090;
        bus.b_bus     = 16'h0060;
        bus.cin_bus   = 4'b0010;
        bus.res_ready = 1'b0;
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.res_valid, 1);
            check("bp_gnt", bus.gnt, 0);
            check("bp_busy", bus.busy, 1);
            check("bp_id", bus.res_id, 1);
            check("bp_sum", bus.res_sum, CIN_EN ? 0 : 15);
            check("bp_cout", bus.res_cout, CIN_EN ? 1 : 0);
            check("bp_par", bus.res_parity, CIN_EN ? 1 : 0);
            bus.req = 4'($urandom);
            @(negedge clk);
        end
        bus.req       = '0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", bus.res_valid, 0);
        check("bp_release_busy", bus.busy, 0);

        // reset during ADD
        wait_idle();
        bus.req   = 4'b0100;
        bus.a_bus = 16'h0500;
        bus.b_bus = 16'h0200;
        @(negedge clk);
        check("mid_gnt", bus.gnt, 4'b0100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", bus.busy, 0);
        check("mid_valid", bus.res_valid, 0);
        check("mid_gnt0", bus.gnt, 0);
        rst     = 1'b0;
        bus.req = 4'b1111;
        @(negedge clk);
        check("mid_next_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
